// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one byte/half/word request at a time against a word-wide dmem port.
// Sub-word stores use read-modify-write. Misaligned or illegal requests respond with an error
// and never touch memory.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               op_we, op_we_nxt;
    logic [2:0]         op_f3, op_f3_nxt;
    logic [1:0]         op_off, op_off_nxt;
    logic [15:0]        op_wdata, op_wdata_nxt;

    logic               req_ready_nxt;
    logic               resp_valid_nxt;
    logic [31:0]        resp_rdata_nxt;
    logic               resp_err_nxt;
    logic               mem_wr_nxt;
    logic [31:0]        mem_addr_nxt;
    logic [31:0]        mem_wdata_nxt;

    logic               req_bad_c;
    logic [7:0]         ld_byte_c;
    logic [15:0]        ld_half_c;
    logic [31:0]        ld_data_c;
    logic [31:0]        merged_c;

    // Request legality: illegal width encoding or misaligned half/word access.
    always_comb begin
        req_bad_c = 1'b0;
        if (req_we) begin
            if (req_funct3[2] || (req_funct3[1:0] == 2'b11)) begin
                req_bad_c = 1'b1;
            end
        end else if (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110) begin
            req_bad_c = 1'b1;
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0]) begin
            req_bad_c = 1'b1;
        end
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) begin
            req_bad_c = 1'b1;
        end
    end

    // Lane extraction with sign/zero extension for loads, lane merge for sub-word stores.
    always_comb begin
        ld_byte_c = mem_rdata[{op_off, 3'b000} +: 8];
        ld_half_c = mem_rdata[{op_off[1], 4'b0000} +: 16];
        case (op_f3)
            3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            3'b100:  ld_data_c = {24'd0, ld_byte_c};
            3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
            3'b101:  ld_data_c = {16'd0, ld_half_c};
            default: ld_data_c = mem_rdata;
        endcase
        merged_c = mem_rdata;
        if (op_f3[1:0] == 2'b00) begin
            merged_c[{op_off, 3'b000} +: 8] = op_wdata[7:0];
        end else begin
            merged_c[{op_off[1], 4'b0000} +: 16] = op_wdata;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        op_we_nxt      = op_we;
        op_f3_nxt      = op_f3;
        op_off_nxt     = op_off;
        op_wdata_nxt   = op_wdata;
        resp_valid_nxt = 1'b0;
        resp_rdata_nxt = resp_rdata;
        resp_err_nxt   = resp_err;
        mem_wr_nxt     = 1'b0;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_we_nxt      = req_we;
                    op_f3_nxt      = req_funct3;
                    op_off_nxt     = req_addr[1:0];
                    op_wdata_nxt   = req_wdata[15:0];
                    resp_rdata_nxt = 32'd0;
                    resp_err_nxt   = 1'b0;
                    if (req_bad_c) begin
                        resp_err_nxt   = 1'b1;
                        resp_valid_nxt = 1'b1;
                        state_nxt      = S_RESP;
                    end else begin
                        mem_addr_nxt = {req_addr[31:2], 2'b00};
                        if (req_we && req_funct3[1:0] == 2'b10) begin
                            mem_wdata_nxt = req_wdata;
                            mem_wr_nxt    = 1'b1;
                            state_nxt     = S_WR;
                        end else begin
                            cnt_nxt   = '0;
                            state_nxt = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_CAP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_CAP: begin
                if (op_we) begin
                    mem_wdata_nxt = merged_c;
                    mem_wr_nxt    = 1'b1;
                    state_nxt     = S_WR;
                end else begin
                    resp_rdata_nxt = ld_data_c;
                    resp_valid_nxt = 1'b1;
                    state_nxt      = S_RESP;
                end
            end
            S_WR: begin
                resp_valid_nxt = 1'b1;
                state_nxt      = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        req_ready_nxt = (state_nxt == S_IDLE);
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_we      <= 1'b0;
            op_f3      <= 3'd0;
            op_off     <= 2'd0;
            op_wdata   <= 16'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            op_we      <= op_we_nxt;
            op_f3      <= op_f3_nxt;
            op_off     <= op_off_nxt;
            op_wdata   <= op_wdata_nxt;
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_err   <= resp_err_nxt;
            mem_wr     <= mem_wr_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, multi-cycle corner sequences and random traffic
// checked against a byte-level reference model.
module tb_lsu_mem_ctrl;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    lsu_mem_ctrl #(.MEM_RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // dmem: 256 words, registered read with LAT cycles of latency, upper address bits wrap
    logic [31:0] dmem [256];
    logic [31:0] rpipe [LAT];
    assign mem_rdata = rpipe[LAT-1];
    always @(posedge clk) begin
        if (mem_wr) dmem[mem_addr[9:2]] <= mem_wdata;
        rpipe[0] <= dmem[mem_addr[9:2]];
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    // reference model memory, byte granular
    logic [7:0] ref_mem [1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Predicts the response and memory effect of one request from the architectural rules.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int lat, output int nwr, output logic [31:0] wword);
        int size, v, base;
        logic legal;
        size = 1 << f3[1:0];
        legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        err = !legal || (int'(a[1:0]) % size != 0);
        rd = 32'd0; nwr = 0; wword = 32'd0;
        base = int'(a[9:0]);
        if (err) begin
            lat = 1;
        end else if (!we) begin
            v = 0;
            for (int i = size - 1; i >= 0; i--) v = v * 256 + int'(ref_mem[base + i]);
            if (size < 4 && !f3[2] && v >= (1 << (8 * size - 1))) v = v - (1 << (8 * size));
            rd = 32'(v);
            lat = 2 + LAT;
        end else begin
            for (int i = 0; i < size; i++) ref_mem[base + i] = wd[8*i +: 8];
            for (int i = 0; i < 4; i++) wword[8*i +: 8] = ref_mem[(base & ~3) + i];
            nwr = 1;
            lat = (size == 4) ? 2 : 3 + LAT;
        end
    endtask

    // Issues one request, observes it cycle by cycle and checks it against the model.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold, input string tag,
                          output logic [31:0] rd, output logic err);
        logic [31:0] e_rd, e_ww, addr0, addr1, w_data, w_addr;
        logic e_err, rdy_bad, got;
        int e_lat, e_nwr, cyc, nwr;
        int guard = 0;
        while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        chk({tag, " ready_wait"}, 32'(req_ready), 32'd1);
        model(we, f3, a, wd, e_rd, e_err, e_lat, e_nwr, e_ww);
        addr0 = mem_addr;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        cyc = 1; nwr = 0; rdy_bad = 1'b0; got = 1'b0;
        rd = 32'd0; err = 1'b0; w_data = 32'd0; w_addr = 32'd0;
        addr1 = mem_addr;
        while (cyc <= 30) begin
            if (!hold) req_valid = 1'b0;
            else begin
                req_we = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
            if (mem_wr) begin nwr++; w_data = mem_wdata; w_addr = mem_addr; end
            if (req_ready) rdy_bad = 1'b1;
            if (resp_valid) begin
                got = 1'b1; rd = resp_rdata; err = resp_err; req_valid = 1'b0;
                break;
            end
            @(posedge clk); #1; cyc++;
        end
        req_valid = 1'b0;
        chk({tag, " resp_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(e_lat));
        chk({tag, " err"}, 32'(err), 32'(e_err));
        chk({tag, " rdata"}, rd, e_rd);
        chk({tag, " wr_count"}, 32'(nwr), 32'(e_nwr));
        chk({tag, " busy_not_ready"}, 32'(rdy_bad), 32'd0);
        chk({tag, " addr_n1"}, addr1, e_err ? addr0 : {a[31:2], 2'b00});
        if (e_nwr == 1) begin
            chk({tag, " wr_data"}, w_data, e_ww);
            chk({tag, " wr_addr"}, w_addr, {a[31:2], 2'b00});
        end
        @(posedge clk); #1;
        chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
        chk({tag, " single_pulse"}, 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [$];
    logic [31:0] rd;
    logic err;
    int nwr6, nrv6;

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = 32'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
        for (int i = 0; i < LAT; i++) rpipe[i] = 32'd0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset mem_wr", 32'(mem_wr), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs = '{
            '{1'b1, 3'b010, 32'h000, 32'hDEADBEEF, 32'h00000000, 1'b0},
            '{1'b0, 3'b010, 32'h000, 32'h0,        32'hDEADBEEF, 1'b0},
            '{1'b1, 3'b010, 32'h004, 32'h12345678, 32'h00000000, 1'b0},
            '{1'b1, 3'b000, 32'h006, 32'h000000AB, 32'h00000000, 1'b0},
            '{1'b0, 3'b010, 32'h004, 32'h0,        32'h12AB5678, 1'b0},
            '{1'b1, 3'b010, 32'h008, 32'h80FF7F01, 32'h00000000, 1'b0},
            '{1'b0, 3'b000, 32'h009, 32'h0,        32'h0000007F, 1'b0},
            '{1'b0, 3'b000, 32'h00A, 32'h0,        32'hFFFFFFFF, 1'b0},
            '{1'b0, 3'b100, 32'h00B, 32'h0,        32'h00000080, 1'b0},
            '{1'b0, 3'b001, 32'h00A, 32'h0,        32'hFFFF80FF, 1'b0},
            '{1'b0, 3'b101, 32'h008, 32'h0,        32'h00007F01, 1'b0},
            '{1'b0, 3'b010, 32'h002, 32'h0,        32'h00000000, 1'b1},
            '{1'b1, 3'b001, 32'h001, 32'h1234,     32'h00000000, 1'b1},
            '{1'b0, 3'b011, 32'h000, 32'h0,        32'h00000000, 1'b1},
            '{1'b1, 3'b101, 32'h004, 32'h0,        32'h00000000, 1'b1},
            '{1'b1, 3'b010, 32'h3FC, 32'hFFFFFFFF, 32'h00000000, 1'b0},
            '{1'b1, 3'b010, 32'h010, 32'h55555555, 32'h00000000, 1'b0}
        };
        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b0,
                   $sformatf("vec%0d", i), rd, err);
            chk($sformatf("vec%0d table_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d table_err", i), 32'(err), 32'(vecs[i].exp_err));
        end

        // SH under continuous req_valid: one accept only
        do_req(1'b1, 3'b001, 32'h3FE, 32'h0000CAFE, 1'b1, "sh_hold", rd, err);
        do_req(1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0, "sh_hold_lw", rd, err);
        chk("sh_hold word", rd, 32'hCAFEFFFF);

        // reset during CAP of an SB: no write, no response
        nwr6 = 0; nrv6 = 0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h10; req_wdata = 32'h000000AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (mem_wr) nwr6++;
            if (resp_valid) nrv6++;
            if (c == 1) rst = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (mem_wr) nwr6++;
            if (resp_valid) nrv6++;
            if (c == 0) begin
                chk("rst_cap ready", 32'(req_ready), 32'd1);
                chk("rst_cap mem_addr", mem_addr, 32'd0);
            end
            @(posedge clk); #1;
        end
        chk("rst_cap no_write", 32'(nwr6), 32'd0);
        chk("rst_cap no_resp", 32'(nrv6), 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, "rst_cap_lw", rd, err);
        chk("rst_cap word", rd, 32'h55555555);

        // random traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            do_req(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0,
                   $sformatf("rnd%0d", i), rd, err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
